// File: rtl/lzc_share_pkg.sv
// rtl/lzc_share_pkg.sv - shared types, default widths and round-robin helper for lzc_share_ctrl
//
// Purpose : common definitions imported by lzc_core and lzc_share_ctrl.
// Contents: LZC_DATA_W / LZC_CNT_W default widths, state_e FSM encoding,
//           rr_next() round-robin successor index.
package lzc_share_pkg;

   localparam int LZC_DATA_W = 32;
   localparam int LZC_CNT_W  = $clog2(LZC_DATA_W) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Index that follows idx in a ring of n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/lzc_core.sv
// rtl/lzc_core.sv - purely combinational leading-zero counter
//
// Purpose : counts the zero bits above the most significant 1 of operand;
//           an all-zero operand yields DATA_W.
// Ports   : operand [DATA_W-1:0] in  - value to examine
//           count   [CNT_W-1:0]  out - leading-zero count, 0..DATA_W
module lzc_core
   import lzc_share_pkg::*;
#(
   parameter int DATA_W = LZC_DATA_W,
   parameter int CNT_W  = LZC_CNT_W
) (
   input  logic [DATA_W-1:0] operand,
   output logic [CNT_W-1:0]  count
);

   logic found;

   // Scan from the MSB down; the first 1 seen fixes the count, so the
   // default (no 1 anywhere) is DATA_W.
   always_comb begin
      count = CNT_W'(DATA_W);
      found = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (!found && operand[i]) begin
            count = CNT_W'(DATA_W - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lzc_share_ctrl.sv
// rtl/lzc_share_ctrl.sv - round-robin controller time-sharing one LZC among N_REQ requesters
//
// Purpose : arbitrates requesters round-robin, latches the winning operand,
//           holds it EXEC_CYCLES cycles in front of a single lzc_core, then
//           presents the count and owner ID until the consumer accepts it.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           req_valid  [N_REQ]        - per-requester request valid
//           req_data   [N_REQ*DATA_W] - operand i at [i*DATA_W +: DATA_W]
//           req_ready  [N_REQ]        - one-hot-or-zero accept, only in IDLE
//           resp_valid/resp_ready     - result handshake
//           resp_count [CNT_W]        - leading zeros of the accepted operand
//           resp_id    [ID_W]         - requester owning resp_count
//           busy                      - high in EXEC or RESP
// Option  : LZC_SHARE_CTRL_STATS_EN adds stat_grants [N_REQ*16] (per-requester
//           accept counters) and stat_stall [16] (RESP cycles with resp_ready
//           low); both saturate at 16'hFFFF and clear on rst.
module lzc_share_ctrl
   import lzc_share_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = LZC_DATA_W,
   parameter int EXEC_CYCLES = 1,
   parameter int ID_W        = $clog2(N_REQ),
   parameter int CNT_W       = $clog2(DATA_W) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [CNT_W-1:0]          resp_count,
   output logic [ID_W-1:0]           resp_id,
   output logic                      busy
`ifdef LZC_SHARE_CTRL_STATS_EN
   ,
   output logic [N_REQ*16-1:0]       stat_grants,
   output logic [15:0]               stat_stall
`endif
);

   // Wide enough to hold EXEC_CYCLES so the post-increment on the final
   // EXEC cycle never wraps.
   localparam int EC_W = $clog2(EXEC_CYCLES + 1);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [EC_W-1:0]    exec_cnt_q, exec_cnt_d;
   logic [DATA_W-1:0]  operand_q, operand_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic               resp_valid_q, resp_valid_d;
   logic [CNT_W-1:0]   resp_count_q, resp_count_d;
   logic [ID_W-1:0]    resp_id_q, resp_id_d;

   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    scan_idx;
   logic               accept;
   logic [CNT_W-1:0]   lzc_count;

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   // rr_ptr moves past the last served requester, so nobody wins twice in
   // a row while someone else is waiting.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   assign accept    = (state_q == IDLE) && grant_found;
   assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

   lzc_core #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_lzc_core (
      .operand (operand_q),
      .count   (lzc_count)
   );

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      exec_cnt_d   = exec_cnt_q;
      operand_d    = operand_q;
      owner_d      = owner_q;
      resp_valid_d = resp_valid_q;
      resp_count_d = resp_count_q;
      resp_id_d    = resp_id_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               operand_d  = req_data[int'(grant_idx) * DATA_W +: DATA_W];
               owner_d    = grant_idx;
               exec_cnt_d = '0;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            exec_cnt_d = exec_cnt_q + EC_W'(1);
            if (exec_cnt_q == EC_W'(EXEC_CYCLES - 1)) begin
               resp_count_d = lzc_count;
               resp_id_d    = owner_q;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            // Result stays frozen until taken; always pass through IDLE so
            // the next arbitration sees the updated pointer.
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               rr_ptr_d     = ID_W'(rr_next(int'(resp_id_q), N_REQ));
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         exec_cnt_q   <= '0;
         operand_q    <= '0;
         owner_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_count_q <= '0;
         resp_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         exec_cnt_q   <= exec_cnt_d;
         operand_q    <= operand_d;
         owner_q      <= owner_d;
         resp_valid_q <= resp_valid_d;
         resp_count_q <= resp_count_d;
         resp_id_q    <= resp_id_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_count = resp_count_q;
   assign resp_id    = resp_id_q;
   assign busy       = (state_q == EXEC) || (state_q == RESP);

`ifdef LZC_SHARE_CTRL_STATS_EN
   logic [N_REQ-1:0][15:0] stat_grants_q, stat_grants_d;
   logic [15:0]            stat_stall_q, stat_stall_d;

   always_comb begin
      stat_grants_d = stat_grants_q;
      stat_stall_d  = stat_stall_q;
      if (accept && (stat_grants_q[grant_idx] != 16'hFFFF)) begin
         stat_grants_d[grant_idx] = stat_grants_q[grant_idx] + 16'd1;
      end
      if ((state_q == RESP) && !resp_ready && (stat_stall_q != 16'hFFFF)) begin
         stat_stall_d = stat_stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_grants_q <= stat_grants_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   // Packed [N_REQ][16] flattens so requester i lands at [i*16 +: 16].
   assign stat_grants = stat_grants_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule
